mem_request_ctrl: RTL and testbench

//  Request sequencer sitting directly upstream of MainMemory. Queues cache line-fill (read) and

---
 rtl/mem_request_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_mem_request_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_request_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_request_ctrl
// Purpose  : Request sequencer in front of MainMemory. Line-fill reads and
//            write-backs arrive over a valid/ready interface, are queued in a
//            small FIFO, and are executed one at a time against MainMemory.
//            Exactly one response is returned per request, in request order.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            req_*                 - request channel (valid/ready)
//            rsp_*                 - response channel (valid/ready)
//            mem_*                 - MainMemory address/data/control
//            busy                  - FSM active or requests still queued
// Options  : MEM_REQ_PAGE_CHECK_EN - when defined, a read whose returned page
//            reference differs from the requested page completes with
//            rsp_err=1 (memory contents are still returned).
// Revision : 1.0 - initial release
// ============================================================================
module mem_request_ctrl #(
   parameter int INDEX_W    = 10,
   parameter int PAGE_W     = 16,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int MEM_LINES  = 512,
   parameter int READ_LAT   = 1
) (
   input  logic               clk,
   input  logic               reset,
   // request channel
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_write,
   input  logic [INDEX_W-1:0] req_index,
   input  logic [PAGE_W-1:0]  req_page,
   input  logic [DATA_W-1:0]  req_wdata,
   input  logic [1:0]         req_mesi,
   // response channel
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_write,
   output logic [DATA_W-1:0]  rsp_data,
   output logic [1:0]         rsp_mesi,
   output logic [PAGE_W-1:0]  rsp_page,
   output logic               rsp_err,
   // MainMemory interface
   output logic [INDEX_W-1:0] mem_index,
   output logic [PAGE_W-1:0]  mem_page,
   output logic [DATA_W-1:0]  mem_wdata,
   output logic               mem_we,
   output logic [1:0]         mem_mesi_in,
   input  logic [DATA_W-1:0]  mem_rdata,
   input  logic [1:0]         mem_mesi_out,
   input  logic [PAGE_W-1:0]  mem_page_out,
   // status
   output logic               busy
);

   localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int c_LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

   localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(FIFO_DEPTH);
   localparam logic [c_LAT_W-1:0] c_LAT_LAST = c_LAT_W'(READ_LAT - 1);
   // One extra bit so MEM_LINES == 2**INDEX_W still compares correctly
   localparam logic [INDEX_W:0]   c_LINES    = (INDEX_W + 1)'(MEM_LINES);

   typedef struct packed {
      logic               write;
      logic [INDEX_W-1:0] index;
      logic [PAGE_W-1:0]  page;
      logic [DATA_W-1:0]  wdata;
      logic [1:0]         mesi;
   } req_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Request queue
   // ------------------------------------------------------------------
   req_t               fifo_q [FIFO_DEPTH];
   logic [c_PTR_W-1:0] wr_ptr_q;
   logic [c_PTR_W-1:0] rd_ptr_q;
   logic [c_CNT_W-1:0] count_q;

   // FSM / request register / registered outputs
   state_t             state_q;
   logic               wr_q;       // current request is a write
   logic               oor_q;      // current request index is out of range
   logic [c_LAT_W-1:0] lat_q;
   logic [INDEX_W-1:0] mem_index_q;
   logic [PAGE_W-1:0]  mem_page_q;
   logic [DATA_W-1:0]  mem_wdata_q;
   logic               mem_we_q;
   logic [1:0]         mem_mesi_q;
   logic               rsp_valid_q;
   logic               rsp_write_q;
   logic [DATA_W-1:0]  rsp_data_q;
   logic [1:0]         rsp_mesi_q;
   logic [PAGE_W-1:0]  rsp_page_q;
   logic               rsp_err_q;

   req_t w_req_in;
   req_t w_head;
   logic w_push;
   logic w_pop;
   logic w_bypass;
   logic w_enq;
   logic w_load;
   logic w_in_range;

   assign req_ready = (count_q != c_FULL);
   assign w_push    = req_valid && req_ready;
   assign w_req_in  = {req_write, req_index, req_page, req_wdata, req_mesi};

   // An idle FSM with an empty queue takes the incoming request directly so
   // that ISSUE follows the accept cycle immediately; the entry never lands
   // in the FIFO in that case.
   assign w_pop      = (state_q == ST_IDLE) && (count_q != '0);
   assign w_bypass   = w_push && (state_q == ST_IDLE) && (count_q == '0);
   assign w_enq      = w_push && !w_bypass;
   assign w_load     = w_pop || w_bypass;
   assign w_head     = w_pop ? fifo_q[rd_ptr_q] : w_req_in;
   assign w_in_range = ({1'b0, w_head.index} < c_LINES);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_enq) begin
            fifo_q[wr_ptr_q] <= w_req_in;
            wr_ptr_q         <= wr_ptr_q + c_PTR_W'(1);
         end
         if (w_pop) begin
            rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
         end
         case ({w_enq, w_pop})
            2'b10:   count_q <= count_q + c_CNT_W'(1);
            2'b01:   count_q <= count_q - c_CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Access sequencer. The mem_* registers double as the address/data
   // part of the request register: they are loaded once when a request
   // leaves IDLE and then held until the next in-range request.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         wr_q        <= 1'b0;
         oor_q       <= 1'b0;
         lat_q       <= '0;
         mem_index_q <= '0;
         mem_page_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         mem_mesi_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_mesi_q  <= '0;
         rsp_page_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         mem_we_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (w_load) begin
                  wr_q    <= w_head.write;
                  oor_q   <= !w_in_range;
                  state_q <= ST_ISSUE;
                  // Out-of-range requests leave the memory port untouched;
                  // they still spend one ISSUE slot so every request sees
                  // the same minimum latency.
                  if (w_in_range) begin
                     mem_index_q <= w_head.index;
                     mem_page_q  <= w_head.page;
                     mem_wdata_q <= w_head.wdata;
                     mem_mesi_q  <= w_head.mesi;
                     mem_we_q    <= w_head.write;
                  end
               end
            end
            ST_ISSUE: begin
               lat_q <= '0;
               if (oor_q || wr_q) begin
                  rsp_valid_q <= 1'b1;
                  rsp_write_q <= wr_q;
                  rsp_data_q  <= '0;
                  rsp_mesi_q  <= '0;
                  rsp_page_q  <= '0;
                  rsp_err_q   <= oor_q;
                  state_q     <= ST_RESP;
               end else begin
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (lat_q == c_LAT_LAST) begin
                  rsp_valid_q <= 1'b1;
                  rsp_write_q <= 1'b0;
                  rsp_data_q  <= mem_rdata;
                  rsp_mesi_q  <= mem_mesi_out;
                  rsp_page_q  <= mem_page_out;
`ifdef MEM_REQ_PAGE_CHECK_EN
                  // mem_page_q still holds the requested page of this read
                  rsp_err_q   <= (mem_page_out != mem_page_q);
`else
                  rsp_err_q   <= 1'b0;
`endif
                  state_q     <= ST_RESP;
               end else begin
                  lat_q <= lat_q + c_LAT_W'(1);
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign mem_index   = mem_index_q;
   assign mem_page    = mem_page_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_we      = mem_we_q;
   assign mem_mesi_in = mem_mesi_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_write   = rsp_write_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_mesi    = rsp_mesi_q;
   assign rsp_page    = rsp_page_q;
   assign rsp_err     = rsp_err_q;
   assign busy        = (state_q != ST_IDLE) || (count_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_mem_request_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_request_ctrl
// Purpose  : Self-checking bench for mem_request_ctrl. A behavioural model
//            (memory map + expected-response queue) predicts every response;
//            directed sequences check cycle timing, backpressure and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_request_ctrl;

   localparam int INDEX_W    = 10;
   localparam int PAGE_W     = 16;
   localparam int DATA_W     = 32;
   localparam int FIFO_DEPTH = 4;
   localparam int MEM_LINES  = 512;
   localparam int READ_LAT   = 1;
`ifdef MEM_REQ_PAGE_CHECK_EN
   localparam bit PAGE_CHK = 1'b1;
`else
   localparam bit PAGE_CHK = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               req_valid = 1'b0;
   logic               req_ready;
   logic               req_write = 1'b0;
   logic [INDEX_W-1:0] req_index = '0;
   logic [PAGE_W-1:0]  req_page = '0;
   logic [DATA_W-1:0]  req_wdata = '0;
   logic [1:0]         req_mesi = '0;
   logic               rsp_valid;
   logic               rsp_ready = 1'b0;
   logic               rsp_write;
   logic [DATA_W-1:0]  rsp_data;
   logic [1:0]         rsp_mesi;
   logic [PAGE_W-1:0]  rsp_page;
   logic               rsp_err;
   logic [INDEX_W-1:0] mem_index;
   logic [PAGE_W-1:0]  mem_page;
   logic [DATA_W-1:0]  mem_wdata;
   logic               mem_we;
   logic [1:0]         mem_mesi_in;
   logic [DATA_W-1:0]  mem_rdata;
   logic [1:0]         mem_mesi_out;
   logic [PAGE_W-1:0]  mem_page_out;
   logic               busy;

   always #5 clk = ~clk;

   mem_request_ctrl #(
      .INDEX_W(INDEX_W), .PAGE_W(PAGE_W), .DATA_W(DATA_W),
      .FIFO_DEPTH(FIFO_DEPTH), .MEM_LINES(MEM_LINES), .READ_LAT(READ_LAT)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_index(req_index), .req_page(req_page), .req_wdata(req_wdata),
      .req_mesi(req_mesi),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_data(rsp_data), .rsp_mesi(rsp_mesi), .rsp_page(rsp_page),
      .rsp_err(rsp_err),
      .mem_index(mem_index), .mem_page(mem_page), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_mesi_in(mem_mesi_in), .mem_rdata(mem_rdata),
      .mem_mesi_out(mem_mesi_out), .mem_page_out(mem_page_out),
      .busy(busy)
   );

   // MainMemory stand-in: registered read, one cycle latency
   logic [49:0] mem_arr [1024] = '{default: '0};
   logic [49:0] mem_rd_q = '0;
   always @(posedge clk) begin
      if (mem_we) mem_arr[mem_index] <= {mem_page, mem_wdata, mem_mesi_in};
      mem_rd_q <= mem_arr[mem_index];
   end
   assign mem_page_out = mem_rd_q[49:34];
   assign mem_rdata    = mem_rd_q[33:2];
   assign mem_mesi_out = mem_rd_q[1:0];

   // ------------------------------------------------------------------
   // Checking
   // ------------------------------------------------------------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // ------------------------------------------------------------------
   // Reference model: line store plus in-order expected responses
   // ------------------------------------------------------------------
   typedef struct packed {
      logic        wr;
      logic [31:0] data;
      logic [1:0]  mesi;
      logic [15:0] page;
      logic        err;
   } rsp_t;

   rsp_t        exp_q[$];
   logic [49:0] model_mem [int];
   int          n_we_seen  = 0;
   int          n_wr_exp   = 0;
   int          n_rsp_seen = 0;

   task automatic model_accept();
      rsp_t        e;
      logic [49:0] s;
      e    = '0;
      e.wr = req_write;
      if (int'(req_index) >= MEM_LINES) begin
         e.err = 1'b1;
      end else if (req_write) begin
         model_mem[int'(req_index)] = {req_page, req_wdata, req_mesi};
         n_wr_exp++;
      end else begin
         s      = model_mem.exists(int'(req_index)) ? model_mem[int'(req_index)] : 50'd0;
         e.page = s[49:34];
         e.data = s[33:2];
         e.mesi = s[1:0];
         e.err  = PAGE_CHK && (s[49:34] != req_page);
      end
      exp_q.push_back(e);
   endtask

   // Monitor: samples on the falling edge, mid-cycle
   initial begin
      rsp_t cur;
      rsp_t held;
      rsp_t e;
      bit   hold;
      hold = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         cur = {rsp_write, rsp_data, rsp_mesi, rsp_page, rsp_err};
         if (reset) begin
            exp_q.delete();
            hold = 1'b0;
         end else begin
            if (mem_we) begin
               n_we_seen++;
               check("we_in_range", 64'(int'(mem_index) < MEM_LINES), 64'd1);
            end
            if (hold) begin
               check("rsp_held_valid", 64'(rsp_valid), 64'd1);
               check("rsp_held_stable", 64'(cur), 64'(held));
            end
            if (req_valid && req_ready) model_accept();
            if (rsp_valid && rsp_ready) begin
               n_rsp_seen++;
               check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("rsp_write", 64'(rsp_write), 64'(e.wr));
                  check("rsp_data",  64'(rsp_data),  64'(e.data));
                  check("rsp_mesi",  64'(rsp_mesi),  64'(e.mesi));
                  check("rsp_page",  64'(rsp_page),  64'(e.page));
                  check("rsp_err",   64'(rsp_err),   64'(e.err));
               end
            end
            hold = rsp_valid && !rsp_ready;
            held = cur;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic w, input int idx, input logic [15:0] pg,
                          input logic [31:0] d, input logic [1:0] m);
      req_valid = 1'b1;
      req_write = w;
      req_index = INDEX_W'(idx);
      req_page  = pg;
      req_wdata = d;
      req_mesi  = m;
   endtask

   task automatic push(input logic w, input int idx, input logic [15:0] pg,
                       input logic [31:0] d, input logic [1:0] m);
      set_req(w, idx, pg, d, m);
      for (int t = 0; t < 50 && !req_ready; t++) step();
      check("push_ready", 64'(req_ready), 64'd1);
      step();
      req_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int t = 0; t < 300 && (exp_q.size() != 0 || busy); t++) step();
      check(tag, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------
   initial begin
      int   rsp_before;
      int   late;
      int   sent;
      bit   fired;
      logic [INDEX_W-1:0] idx_before;

      // Reset state
      repeat (3) step();
      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_busy",      64'(busy),      64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_mem_we",    64'(mem_we),    64'd0);
      check("rst_mem_index", 64'(mem_index), 64'd0);
      check("rst_rsp_data",  64'(rsp_data),  64'd0);
      reset = 1'b0;
      step();

      // 1: write idx 5, exact cycle timing
      rsp_ready = 1'b1;
      set_req(1'b1, 5, 16'h0001, 32'hDEAD_BEEF, 2'd2);
      check("t1_ready", 64'(req_ready), 64'd1);
      step(); req_valid = 1'b0;                           // cycle 1
      check("t1_we",        64'(mem_we),      64'd1);
      check("t1_index",     64'(mem_index),   64'd5);
      check("t1_page",      64'(mem_page),    64'h0001);
      check("t1_wdata",     64'(mem_wdata),   64'hDEAD_BEEF);
      check("t1_mesi",      64'(mem_mesi_in), 64'd2);
      check("t1_rsp_c1",    64'(rsp_valid),   64'd0);
      step();                                             // cycle 2
      check("t1_we_off",    64'(mem_we),      64'd0);
      check("t1_rsp_c2",    64'(rsp_valid),   64'd1);
      check("t1_err",       64'(rsp_err),     64'd0);
      step();
      check("t1_done_busy", 64'(busy),        64'd0);

      // 2: read back idx 5
      set_req(1'b0, 5, 16'h0001, 32'h0, 2'd0);
      step(); req_valid = 1'b0;                           // cycle 1
      check("t2_we",     64'(mem_we),    64'd0);
      check("t2_index",  64'(mem_index), 64'd5);
      step();                                             // cycle 2
      check("t2_rsp_c2", 64'(rsp_valid), 64'd0);
      step();                                             // cycle 3
      check("t2_rsp_c3", 64'(rsp_valid), 64'd1);
      check("t2_data",   64'(rsp_data),  64'hDEAD_BEEF);
      check("t2_mesi",   64'(rsp_mesi),  64'd2);
      check("t2_page",   64'(rsp_page),  64'h0001);
      check("t2_err",    64'(rsp_err),   64'd0);
      step();

      // 3: out-of-range read
      idx_before = mem_index;
      set_req(1'b0, 600, 16'h0001, 32'h0, 2'd0);
      step(); req_valid = 1'b0;                           // cycle 1
      check("t3_we",        64'(mem_we),    64'd0);
      check("t3_rsp_c1",    64'(rsp_valid), 64'd0);
      step();                                             // cycle 2
      check("t3_rsp_c2",    64'(rsp_valid), 64'd1);
      check("t3_err",       64'(rsp_err),   64'd1);
      check("t3_data",      64'(rsp_data),  64'd0);
      check("t3_index_kept", 64'(mem_index), 64'(idx_before));
      step();

      // 4: backpressure, queue fills, in-order release
      rsp_ready  = 1'b0;
      rsp_before = n_rsp_seen;
      push(1'b1, 20, 16'h0003, 32'h1111_0000, 2'd1);
      push(1'b0, 20, 16'h0003, 32'h0, 2'd0);
      push(1'b0, 5,  16'h0001, 32'h0, 2'd0);
      push(1'b1, 21, 16'h0000, 32'h0000_2222, 2'd3);
      push(1'b0, 21, 16'h0000, 32'h0, 2'd0);
      set_req(1'b1, 22, 16'h0009, 32'h9999_9999, 2'd1);  // must be refused
      check("t4_full_ready", 64'(req_ready), 64'd0);
      step();
      check("t4_full_hold",  64'(req_ready), 64'd0);
      check("t4_busy",       64'(busy),      64'd1);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      drain("t4_drain");
      check("t4_rsp_count", 64'(n_rsp_seen - rsp_before), 64'd5);

      // 5: reset while in WAIT with three requests queued
      rsp_ready = 1'b0;
      push(1'b0, 5,  16'h0001, 32'h0, 2'd0);
      push(1'b0, 30, 16'h0000, 32'h0, 2'd0);
      push(1'b0, 31, 16'h0000, 32'h0, 2'd0);
      push(1'b0, 32, 16'h0000, 32'h0, 2'd0);
      push(1'b0, 33, 16'h0000, 32'h0, 2'd0);
      for (int t = 0; t < 50 && !rsp_valid; t++) step();
      check("t5_first_rsp", 64'(rsp_valid), 64'd1);
      rsp_ready = 1'b1;
      step();                                             // IDLE, pops idx 30
      step();                                             // ISSUE
      check("t5_issue_idx", 64'(mem_index), 64'd30);
      step();                                             // WAIT
      reset = 1'b1;
      step();
      check("t5_busy",      64'(busy),      64'd0);
      check("t5_rsp_valid", 64'(rsp_valid), 64'd0);
      check("t5_req_ready", 64'(req_ready), 64'd1);
      check("t5_we",        64'(mem_we),    64'd0);
      reset = 1'b0;
      late  = 0;
      repeat (12) begin
         step();
         if (rsp_valid) late++;
      end
      check("t5_no_late", 64'(late), 64'd0);

      // 6: page mismatch on read
      set_req(1'b0, 5, 16'h0002, 32'h0, 2'd0);
      step(); req_valid = 1'b0;
      step();
      step();
      check("t6_rsp",  64'(rsp_valid), 64'd1);
      check("t6_err",  64'(rsp_err),   64'(PAGE_CHK));
      check("t6_page", 64'(rsp_page),  64'h0001);
      check("t6_data", 64'(rsp_data),  64'hDEAD_BEEF);
      step();

      // Randomized traffic against the model
      sent  = 0;
      fired = 1'b0;
      for (int cyc = 0; cyc < 6000 && sent < 300; cyc++) begin
         if (!req_valid && ($urandom % 10 < 7)) begin
            set_req(1'($urandom % 2),
                    ($urandom % 5 == 0) ? int'($urandom_range(512, 1023)) : int'($urandom_range(0, 15)),
                    16'($urandom_range(0, 3)), 32'($urandom), 2'($urandom % 4));
         end
         rsp_ready = ($urandom % 10 < 7);
         @(negedge clk);
         fired = req_valid && req_ready;
         step();
         if (fired) begin
            sent++;
            req_valid = 1'b0;
         end
      end
      check("rand_sent", 64'(sent), 64'd300);
      rsp_ready = 1'b1;
      drain("rand_drain");
      check("rand_idle",  64'(busy),      64'd0);
      check("we_count",   64'(n_we_seen), 64'(n_wr_exp));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
